// File: rtl/nibble_serial_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor: one nibble per clock through a single
// 4-bit carry-lookahead slice, LSB nibble first, with a registered ripple carry.
module nibble_serial_addsub #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             sub_flag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; valid, once raised, holds its payload stable until that edge.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             carry_q, carry_d;
   logic             sub_q, sub_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [3:0] a_nib, b_nib, bx_nib, g, p, slice_sum;
   logic [4:0] c;

   // Carry-lookahead slice on the current nibble; B is inverted for subtraction.
   always_comb begin
      a_nib  = a_q[4*idx_q +: 4];
      b_nib  = b_q[4*idx_q +: 4];
      bx_nib = sub_q ? ~b_nib : b_nib;
      g      = a_nib & bx_nib;
      p      = a_nib ^ bx_nib;
      c[0]   = carry_q;
      c[1]   = g[0] | (p[0] & c[0]);
      c[2]   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3]   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
      c[4]   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
      slice_sum = p ^ c[3:0];
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      sub_d   = sub_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = src1;
               b_d     = src2;
               sub_d   = sub_flag;
               carry_d = sub_flag;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[4*idx_q +: 4] = slice_sum;
            carry_d             = c[4];
            idx_d               = idx_q + IW'(1);
            if (idx_q == IW'(NIB - 1)) begin
               cout_d  = c[4];
               ovf_d   = (a_nib[3] == bx_nib[3]) && (slice_sum[3] != a_nib[3]);
               idx_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         sub_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         sub_q   <= sub_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign carry_out = cout_q;
   assign overflow  = ovf_q;

endmodule
